// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-cache request/response, PC redirect and issue handshake.
// master = fetch controller, slave = cache/redirect/decoder environment.
interface fetch_ctrl_if;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_valid;
  logic [31:0] icache_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        iss_valid;
  logic [31:0] iss_ins;
  logic [31:0] iss_pc;
  logic        iss_ready;

  modport master (
    output icache_req, icache_addr, iss_valid, iss_ins, iss_pc,
    input  icache_valid, icache_data, redirect_valid, redirect_pc, iss_ready
  );

  modport slave (
    input  icache_req, icache_addr, iss_valid, iss_ins, iss_pc,
    output icache_valid, icache_data, redirect_valid, redirect_pc, iss_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding icache request, JAL-aware next-PC,
// redirect flush, and a circular instruction queue feeding the decoder.
//
// state | meaning
// IDLE  | no request outstanding; issue one when the queue has room
// WAIT  | request outstanding; address held until the response strobe
// DROP  | request outstanding but redirected; its response is discarded
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 4
) (
  input logic          clk_in,
  input logic          rst_in,
  input logic          rdy_in,
  fetch_ctrl_if.master bus
);
  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state_q, state_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic [31:0]   mem_ins [QDEPTH];
  logic [31:0]   mem_pc  [QDEPTH];
  logic          enq, deq, flush, iss_valid;
  logic [31:0]   jal_imm, pc_seq;

  assign jal_imm = {{11{bus.icache_data[31]}}, bus.icache_data[31], bus.icache_data[19:12],
                    bus.icache_data[20], bus.icache_data[30:21], 1'b0};
  assign pc_seq  = (bus.icache_data[6:0] == 7'b1101111) ? pc_q + jal_imm : pc_q + 32'd4;

  assign iss_valid   = (count_q != '0);
  assign bus.iss_valid = iss_valid;
  assign bus.iss_ins   = iss_valid ? mem_ins[head_q] : '0;
  assign bus.iss_pc    = iss_valid ? mem_pc[head_q]  : '0;
  assign bus.icache_req  = req_q;
  assign bus.icache_addr = addr_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    enq     = 1'b0;
    flush   = 1'b0;
    deq     = rdy_in & iss_valid & bus.iss_ready & ~bus.redirect_valid;
    if (rdy_in) begin
      if (bus.redirect_valid) begin
        flush = 1'b1;
        pc_d  = bus.redirect_pc;
      end
      unique case (state_q)
        IDLE: begin
          // Full-queue test uses the registered count, so a same-cycle dequeue delays the request by one cycle.
          if (!bus.redirect_valid && count_q < FULL) begin
            state_d = WAIT;
            req_d   = 1'b1;
            addr_d  = pc_q;
          end
        end
        WAIT: begin
          if (bus.redirect_valid) begin
            req_d   = 1'b0;
            state_d = bus.icache_valid ? IDLE : DROP;
          end else if (bus.icache_valid) begin
            req_d   = 1'b0;
            enq     = 1'b1;
            pc_d    = pc_seq;
            state_d = IDLE;
          end
        end
        DROP: begin
          if (bus.icache_valid) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) tail_q <= tail_q + 1'b1;
      if (deq) head_q <= head_q + 1'b1;
      if (enq && !deq)      count_q <= count_q + 1'b1;
      else if (!enq && deq) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && enq) begin
      mem_ins[tail_q] <= bus.icache_data;
      mem_pc[tail_q]  <= pc_q;
    end
  end
endmodule
